// File: rtl/load_store_sched.sv
// load_store_sched
//   Round-robin scheduler sharing one bounded volume counter (0..N) between
//   NREQ requesters. A granted requester fills (+1) or drains (-1) the volume
//   once per cycle until it drops its request or reaches a bound. Every
//   release is followed by a HOLD-cycle turnaround before the next grant.
//   This block is the only writer of the volume.
//
//   Optional build macro: LS_QUOTA_EN
//     When defined, a grant is also released after QUOTA volume steps.
//     This keeps one requester from holding the volume under continuous
//     requests.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   req_fill   in   [NREQ]  per-requester fill request
//   req_drain  in   [NREQ]  per-requester drain request
//   grant      out  [NREQ]  registered one-hot grant, zero when idle
//   grant_dir  out  1 = fill, 0 = drain (valid while grant != 0)
//   vol        out  [CBITS] current volume
//   full       out  vol == N
//   empty      out  vol == 0
//   busy       out  state != IDLE
module load_store_sched #(
  parameter int N     = 10000,
  parameter int CBITS = 14,
  parameter int NREQ  = 2,
  parameter int HOLD  = 4,
  parameter int QUOTA = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_fill,
  input  logic [NREQ-1:0]  req_drain,
  output logic [NREQ-1:0]  grant,
  output logic             grant_dir,
  output logic [CBITS-1:0] vol,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, TURN} state_t;

  state_t           r_state,  w_state_nx;
  logic [CBITS-1:0] r_vol,    w_vol_nx;
  logic [NREQ-1:0]  r_grant,  w_grant_nx;
  logic             r_dir,    w_dir_nx;
  logic [PW-1:0]    r_rr_ptr, w_rr_nx;
  logic [PW-1:0]    r_gidx,   w_gidx_nx;
  logic [HW-1:0]    r_hold,   w_hold_nx;
`ifdef LS_QUOTA_EN
  logic [CBITS-1:0] r_steps,  w_steps_nx;
`endif

  logic [NREQ-1:0]  w_fill_ok;
  logic [NREQ-1:0]  w_drain_ok;
  logic [NREQ-1:0]  w_elig;
  logic             w_found;
  logic [PW-1:0]    w_pick;
  logic [PW-1:0]    w_next_ptr;
  logic             w_not_full;
  logic             w_not_empty;
  logic             w_quota_hit;

  assign w_not_full  = (r_vol < CBITS'(N));
  assign w_not_empty = (r_vol != '0);
  assign w_fill_ok   = req_fill  & {NREQ{w_not_full}};
  assign w_drain_ok  = req_drain & {NREQ{w_not_empty}};
  assign w_elig      = w_fill_ok | w_drain_ok;

  // Pointer handed to the next search after the current grantee releases.
  assign w_next_ptr = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + PW'(1);

`ifdef LS_QUOTA_EN
  assign w_quota_hit = (r_steps == CBITS'(QUOTA));
`else
  assign w_quota_hit = 1'b0;
`endif

  // Round-robin search: first eligible requester at or after r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_vol_nx   = r_vol;
    w_grant_nx = r_grant;
    w_dir_nx   = r_dir;
    w_rr_nx    = r_rr_ptr;
    w_gidx_nx  = r_gidx;
    w_hold_nx  = r_hold;
`ifdef LS_QUOTA_EN
    w_steps_nx = r_steps;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nx = NREQ'(1) << w_pick;
          w_gidx_nx  = w_pick;
          // Fill wins when the same requester is eligible both ways.
          w_dir_nx   = w_fill_ok[w_pick];
          w_state_nx = w_fill_ok[w_pick] ? FILL : DRAIN;
`ifdef LS_QUOTA_EN
          w_steps_nx = '0;
`endif
        end
      end
      FILL, DRAIN: begin
        if (!w_quota_hit &&
            ((r_state == FILL)  && req_fill[r_gidx]  && w_not_full ||
             (r_state == DRAIN) && req_drain[r_gidx] && w_not_empty)) begin
          w_vol_nx = (r_state == FILL) ? r_vol + CBITS'(1) : r_vol - CBITS'(1);
`ifdef LS_QUOTA_EN
          w_steps_nx = r_steps + CBITS'(1);
`endif
        end else begin
          w_grant_nx = '0;
          w_rr_nx    = w_next_ptr;
          w_hold_nx  = HW'(HOLD - 1);
          w_state_nx = TURN;
        end
      end
      TURN: begin
        if (r_hold == '0) begin
          w_state_nx = IDLE;
        end else begin
          w_hold_nx = r_hold - HW'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_vol    <= '0;
      r_grant  <= '0;
      r_dir    <= 1'b0;
      r_rr_ptr <= '0;
      r_gidx   <= '0;
      r_hold   <= '0;
`ifdef LS_QUOTA_EN
      r_steps  <= '0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_vol    <= w_vol_nx;
      r_grant  <= w_grant_nx;
      r_dir    <= w_dir_nx;
      r_rr_ptr <= w_rr_nx;
      r_gidx   <= w_gidx_nx;
      r_hold   <= w_hold_nx;
`ifdef LS_QUOTA_EN
      r_steps  <= w_steps_nx;
`endif
    end
  end

  assign grant     = r_grant;
  assign grant_dir = r_dir;
  assign vol       = r_vol;
  assign full      = (r_vol == CBITS'(N));
  assign empty     = (r_vol == '0);
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_load_store_sched.sv
// Directed bench for load_store_sched with N=8, CBITS=4, NREQ=2, HOLD=2,
// QUOTA=3. Outputs are sampled 1 time unit after each rising edge.
module tb_load_store_sched;

  logic       clk;
  logic       rst;
  logic [1:0] req_fill;
  logic [1:0] req_drain;
  logic [1:0] grant;
  logic       grant_dir;
  logic [3:0] vol;
  logic       full;
  logic       empty;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  load_store_sched #(
    .N(8), .CBITS(4), .NREQ(2), .HOLD(2), .QUOTA(3)
  ) dut (
    .clk(clk), .rst(rst), .req_fill(req_fill), .req_drain(req_drain),
    .grant(grant), .grant_dir(grant_dir), .vol(vol),
    .full(full), .empty(empty), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called right after a release has been sampled; walks to the next grant,
  // counting cycles where busy is high and no grant is held (TURN cycles).
  task automatic gap(output int turns, output logic [1:0] g);
    turns = (busy && grant == 2'b00) ? 1 : 0;
    g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      step();
      if (grant != 2'b00) begin
        g = grant;
        break;
      end
      if (busy) turns++;
    end
  endtask

  int         t;
  logic [1:0] g;

  initial begin
    rst = 1'b1; req_fill = 2'b00; req_drain = 2'b00;
    step(); step();
    chk("rst_vol", vol, 0);
    chk("rst_grant", grant, 0);
    chk("rst_dir", grant_dir, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // 1: fill from requester 0 up to the bound
    req_fill = 2'b01;
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_dir", grant_dir, 1);
    chk("t1_vol0", vol, 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t1_vol", vol, 32'(i));
    end
    chk("t1_full", full, 1);
    step();
    chk("t1_rel_grant", grant, 0);
    chk("t1_rel_busy", busy, 1);
    chk("t1_vol_hold", vol, 8);
    step();
    chk("t1_turn2_grant", grant, 0);
    chk("t1_turn2_busy", busy, 1);
    step();
    chk("t1_idle_busy", busy, 0);
    for (int i = 0; i < 4; i++) step();
    chk("t1_no_regrant", grant, 0);
    chk("t1_vol_full", vol, 8);

    // 2: drain from requester 1 down to zero
    req_fill = 2'b00; req_drain = 2'b10;
    step();
    chk("t2_grant", grant, 2'b10);
    chk("t2_dir", grant_dir, 0);
    for (int i = 7; i >= 0; i--) begin
      step();
      chk("t2_vol", vol, 32'(i));
    end
    chk("t2_empty", empty, 1);
    step();
    chk("t2_rel_grant", grant, 0);
    req_drain = 2'b00;
    step(); step();
    chk("t2_idle", busy, 0);

    // 3: both requesters fill; rr_ptr is 0, so requester 0 goes first
    req_fill = 2'b11;
    step();
    chk("t3_grant_a", grant, 2'b01);
    step(); step();
    chk("t3_vol_a", vol, 2);
    req_fill = 2'b10;
    step();
    chk("t3_rel_a", grant, 0);
    req_fill = 2'b11;
    gap(t, g);
    chk("t3_turns_ab", t, 2);
    chk("t3_grant_b", g, 2'b10);
    step(); step();
    chk("t3_vol_b", vol, 4);
    req_fill = 2'b01;
    step();
    chk("t3_rel_b", grant, 0);
    req_fill = 2'b11;
    gap(t, g);
    chk("t3_turns_ba", t, 2);
    chk("t3_grant_c", g, 2'b01);
    step(); step();
    chk("t3_vol_c", vol, 6);
    req_fill = 2'b00;
    step();
    chk("t3_rel_c", grant, 0);
    step(); step();

    // back to zero through requester 0 draining; drop comes from the bound
    req_drain = 2'b01;
    step();
    chk("t4p_grant", grant, 2'b01);
    chk("t4p_dir", grant_dir, 0);
    for (int i = 0; i < 6; i++) step();
    chk("t4p_vol", vol, 0);
    step();
    chk("t4p_rel", grant, 0);
    chk("t4p_vol_floor", vol, 0);
    req_drain = 2'b00;
    step(); step();

    // 4: fill and drain asserted together at vol=0
    req_fill = 2'b01; req_drain = 2'b01;
    step();
    chk("t4_grant", grant, 2'b01);
    chk("t4_dir", grant_dir, 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t4_vol", vol, 32'(i));
      chk("t4_dir_hold", grant_dir, 1);
    end

    // 5: reset in the middle of a fill grant at vol=5
    rst = 1'b1;
    step();
    chk("t5_vol", vol, 0);
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_empty", empty, 1);
    chk("t5_dir", grant_dir, 0);
    rst = 1'b0; req_fill = 2'b00; req_drain = 2'b00;
    step();
    chk("t5_stay_idle", busy, 0);

    // 6: continuous fill from requester 0
    req_fill = 2'b01;
    step();
    chk("t6_grant", grant, 2'b01);
`ifdef LS_QUOTA_EN
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("t6_vol_q1", vol, 32'(i));
    end
    step();
    chk("t6_rel_q", grant, 0);
    chk("t6_vol_q_hold", vol, 3);
    gap(t, g);
    chk("t6_turns", t, 2);
    chk("t6_regrant", g, 2'b01);
    for (int i = 4; i <= 6; i++) begin
      step();
      chk("t6_vol_q2", vol, 32'(i));
    end
`else
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t6_vol", vol, 32'(i));
    end
    step();
    chk("t6_rel", grant, 0);
    chk("t6_full", full, 1);
`endif
    req_fill = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
